// File: rtl/cp0_nested_pkg.sv
// cp0_nested_pkg: CP0 register indices, exception source indices and the CAUSE encoding helper.
package cp0_nested_pkg;
  localparam int REG_COUNT   = 9;
  localparam int REG_COMPARE = 11;
  localparam int REG_STATUS  = 12;
  localparam int REG_CAUSE   = 13;
  localparam int REG_EPC     = 14;
  localparam int SRC_SYSCALL = 0;
  localparam int SRC_BREAK   = 1;
  localparam int SRC_TEQ     = 2;
  function automatic logic [6:0] cause_code(input logic [4:0] idx);
    return {idx, 2'b00};
  endfunction
endpackage

// File: rtl/cp0_epc_stack.sv
// cp0_epc_stack: DEPTH-entry EPC LIFO with push, pop, write-top and a top output; pop when empty is a no-op.
module cp0_epc_stack #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 3,
  parameter int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              wr_top,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] top,
  output logic [CW-1:0]     cnt
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [CW-1:0]     top_idx;
  // an empty stack still exposes slot 0 so a stray eret has a defined target
  assign top_idx = (cnt == '0) ? '0 : cnt - CW'(1);
  assign top     = mem[top_idx];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && cnt < CW'(DEPTH)) begin
      mem[cnt] <= din;
      cnt      <= cnt + CW'(1);
    end else if (pop && cnt != '0) begin
      cnt <= cnt - CW'(1);
    end else if (wr_top) begin
      mem[top_idx] <= din;
    end
  end
endmodule

// File: rtl/cp0_nested.sv
// cp0_nested: coprocessor-0 with prioritised maskable exceptions, Count/Compare timer and nested STATUS/EPC stacks.
module cp0_nested
  import cp0_nested_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 5,
  parameter int                NUM_EXC    = 4,
  parameter int                NEST_DEPTH = 3,
  parameter logic [DATA_W-1:0] EXC_VECTOR = 'h4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            mtc0,
  input  logic [ADDR_W-1:0]               addr,
  input  logic [DATA_W-1:0]               wdata,
  input  logic [DATA_W-1:0]               pc,
  input  logic [NUM_EXC-1:0]              exc_req,
  input  logic                            eret,
  output logic [DATA_W-1:0]               rdata,
  output logic [DATA_W-1:0]               exc_addr,
  output logic                            redirect,
  output logic                            exc_taken,
  output logic [$clog2(NEST_DEPTH+1)-1:0] nest_lvl
);
  localparam int NUM_SRC = NUM_EXC + 1;
  localparam int FW      = NUM_SRC + 1;
  localparam int LW      = $clog2(NEST_DEPTH + 1);
  logic [DATA_W-1:0]  regs [2**ADDR_W];
  logic [DATA_W-1:0]  status, epc_top;
  logic [NUM_SRC-1:0] act;
  logic [4:0]         win;
  logic               win_en, timer_pend, do_eret, wr_epc, match;
  assign status  = regs[REG_STATUS];
  assign act     = {timer_pend, exc_req};
  assign do_eret = eret & ~mtc0;
  assign wr_epc  = mtc0 & (addr == ADDR_W'(REG_EPC));
  assign match   = (regs[REG_COUNT] == regs[REG_COMPARE]) & (regs[REG_COMPARE] != '0);
  // descending scan so the lowest active source is the one left standing
  always_comb begin
    win    = '0;
    win_en = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (act[i]) begin
        win    = 5'(i);
        win_en = status[i+1];
      end
  end
  assign exc_taken = ~mtc0 & ~eret & status[0] & (|act) & win_en & (nest_lvl < LW'(NEST_DEPTH));
  assign redirect  = exc_taken | do_eret;
  assign exc_addr  = do_eret ? epc_top : EXC_VECTOR;
  assign rdata     = (addr == ADDR_W'(REG_EPC)) ? epc_top : regs[addr];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
      timer_pend <= 1'b0;
    end else begin
      regs[REG_COUNT] <= regs[REG_COUNT] + DATA_W'(1);
      timer_pend <= (mtc0 && addr == ADDR_W'(REG_COMPARE)) ? 1'b0 :
                    match ? 1'b1 :
                    (exc_taken && win == 5'(NUM_EXC)) ? 1'b0 : timer_pend;
      if (mtc0 && !wr_epc) regs[addr] <= wdata;
      else if (do_eret) regs[REG_STATUS] <= status >> FW;
      else if (exc_taken) begin
        regs[REG_STATUS] <= status << FW;
        regs[REG_CAUSE]  <= DATA_W'(cause_code(win));
      end
    end
  end
  cp0_epc_stack #(.DATA_W(DATA_W), .DEPTH(NEST_DEPTH), .CW(LW)) u_epc (
    .clk    (clk),
    .rst    (rst),
    .push   (exc_taken),
    .pop    (do_eret),
    .wr_top (wr_epc),
    .din    (mtc0 ? wdata : pc),
    .top    (epc_top),
    .cnt    (nest_lvl)
  );
endmodule

// File: tb/tb_cp0_nested.sv
// tb_cp0_nested: directed scenarios plus randomized traffic checked against a queue-based CP0 model.
module tb_cp0_nested;
  localparam int          ND  = 3;
  localparam int          NE  = 4;
  localparam logic [31:0] VEC = 32'h4;
  logic        clk = 0, rst = 0, mtc0 = 0, eret = 0;
  logic [4:0]  addr = 0;
  logic [31:0] wdata = 0, pc = 0;
  logic [3:0]  exc_req = 0;
  logic [31:0] rdata, exc_addr;
  logic        redirect, exc_taken;
  logic [1:0]  nest_lvl;
  logic [31:0] m_reg [32];
  logic [31:0] epc_q [$];
  logic [31:0] epc_floor;
  bit          m_pend;
  logic [31:0] o_rdata, o_addr;
  logic        o_taken;
  int          checks = 0, errors = 0;

  cp0_nested dut (
    .clk(clk), .rst(rst), .mtc0(mtc0), .addr(addr), .wdata(wdata), .pc(pc),
    .exc_req(exc_req), .eret(eret), .rdata(rdata), .exc_addr(exc_addr),
    .redirect(redirect), .exc_taken(exc_taken), .nest_lvl(nest_lvl)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] epc_top();
    return (epc_q.size() != 0) ? epc_q[epc_q.size()-1] : epc_floor;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 0;
    epc_q.delete();
    epc_floor = 0;
    m_pend = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // one clock: drive, check combinational outputs against the model, then advance the model
  task automatic cyc(input bit m, input int a, input logic [31:0] wd, input logic [31:0] p,
                     input logic [3:0] req, input bit er);
    logic [4:0]  act;
    logic [31:0] st, tmp;
    int          win;
    bit          tk;
    mtc0 = m; addr = a[4:0]; wdata = wd; pc = p; exc_req = req; eret = er;
    #1;
    st  = m_reg[12];
    act = {m_pend, req};
    win = -1;
    for (int i = 0; i < NE + 1; i++) if (act[i] && win < 0) win = i;
    tk = !m && !er && st[0] && win >= 0 && st[win+1] && epc_q.size() < ND;
    o_rdata = rdata; o_addr = exc_addr; o_taken = exc_taken;
    chk("exc_taken", 32'(exc_taken), 32'(tk));
    chk("exc_addr", exc_addr, er ? epc_top() : VEC);
    chk("redirect", 32'(redirect), 32'(tk | er));
    chk("nest_lvl", 32'(nest_lvl), 32'(epc_q.size()));
    chk("rdata", rdata, (a == 14) ? epc_top() : m_reg[a]);
    @(posedge clk);
    if (m && a == 11) m_pend = 0;
    else if (m_reg[9] == m_reg[11] && m_reg[11] != 0) m_pend = 1;
    else if (tk && win == NE) m_pend = 0;
    m_reg[9] = m_reg[9] + 1;
    if (m) begin
      if (a == 14) begin
        if (epc_q.size() != 0) epc_q[epc_q.size()-1] = wd;
        else epc_floor = wd;
      end else m_reg[a] = wd;
    end else if (er) begin
      m_reg[12] = st >> 6;
      if (epc_q.size() != 0) begin
        tmp = epc_q.pop_back();
        if (epc_q.size() == 0) epc_floor = tmp;
      end
    end else if (tk) begin
      m_reg[12] = st << 6;
      m_reg[13] = 32'(win) << 2;
      epc_q.push_back(p);
    end
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic rd(input int a);
    cyc(0, a, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_nest", 32'(nest_lvl), 0);
    chk("rst_vec", exc_addr, VEC);
    chk("rst_taken", 32'(exc_taken), 0);
    rst = 1;
    rd(12); chk("rst_status", o_rdata, 0);
    // single exception, source 0
    cyc(1, 12, 32'h3, 0, 0, 0);
    cyc(0, 0, 0, 32'h40, 4'b0001, 0);
    chk("t1_taken", 32'(o_taken), 1);
    chk("t1_vec", o_addr, 32'h4);
    rd(14); chk("t1_epc", o_rdata, 32'h40);
    rd(13); chk("t1_cause", o_rdata, 32'h0);
    rd(12); chk("t1_status", o_rdata, 32'hC0);
    cyc(0, 0, 0, 0, 0, 1); chk("t1_eret", o_addr, 32'h40);
    // two simultaneous requests: lowest index wins, the other is dropped
    cyc(1, 12, 32'h0D, 0, 0, 0);
    cyc(0, 0, 0, 32'h80, 4'b0110, 0);
    chk("t2_taken", 32'(o_taken), 1);
    rd(13); chk("t2_cause", o_rdata, 32'h4);
    rd(12); chk("t2_status", o_rdata, 32'h340);
    cyc(0, 0, 0, 0, 0, 1);
    // three nested levels, fourth blocked
    cyc(1, 12, 32'h3, 0, 0, 0);
    cyc(0, 0, 0, 32'h10, 4'b0001, 0);
    cyc(1, 12, 32'hC3, 0, 0, 0);
    cyc(0, 0, 0, 32'h20, 4'b0001, 0);
    cyc(1, 12, 32'h30C3, 0, 0, 0);
    cyc(0, 0, 0, 32'h30, 4'b0001, 0);
    cyc(1, 12, 32'hC30C3, 0, 0, 0);
    cyc(0, 0, 0, 32'h44, 4'b0001, 0);
    chk("t3_blocked", 32'(o_taken), 0);
    chk("t3_nest", 32'(nest_lvl), 3);
    cyc(0, 0, 0, 0, 0, 1); chk("t3_ret1", o_addr, 32'h30);
    rd(12); chk("t3_st1", o_rdata, 32'h30C3);
    cyc(0, 0, 0, 0, 0, 1); chk("t3_ret2", o_addr, 32'h20);
    rd(12); chk("t3_st2", o_rdata, 32'hC3);
    cyc(0, 0, 0, 0, 0, 1); chk("t3_ret3", o_addr, 32'h10);
    rd(12); chk("t3_st3", o_rdata, 32'h3);
    // timer interrupt
    cyc(1, 12, 32'h21, 0, 0, 0);
    cyc(1, 11, 32'h5, 0, 0, 0);
    cyc(1, 9, 32'h0, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      idle();
      chk("t4_timer", 32'(o_taken), 32'(k == 6));
    end
    rd(13); chk("t4_cause", o_rdata, 32'h10);
    cyc(0, 0, 0, 0, 0, 1);
    // pending timer deferred by mtc0, then cleared by a COMPARE write
    cyc(1, 9, 32'h0, 0, 0, 0);
    repeat (6) idle();
    cyc(1, 3, 32'h1234, 0, 0, 0); chk("t5_defer", 32'(o_taken), 0);
    idle(); chk("t5_late", 32'(o_taken), 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 9, 32'h0, 0, 0, 0);
    repeat (6) idle();
    cyc(1, 11, 32'h100, 0, 0, 0);
    idle(); chk("t5_cleared", 32'(o_taken), 0);
    idle(); chk("t5_cleared2", 32'(o_taken), 0);
    // COUNT wrap
    cyc(1, 9, 32'hFFFF_FFFF, 0, 0, 0);
    rd(9); chk("wrap_max", o_rdata, 32'hFFFF_FFFF);
    rd(9); chk("wrap_zero", o_rdata, 32'h0);
    // async reset mid-nest
    cyc(1, 12, 32'h3, 0, 0, 0);
    cyc(0, 0, 0, 32'h50, 4'b0001, 0);
    cyc(1, 12, 32'hC3, 0, 0, 0);
    cyc(0, 0, 0, 32'h60, 4'b0001, 0);
    chk("t6_nest2", 32'(nest_lvl), 2);
    #2 rst = 0;
    #1 chk("t6_rst_nest", 32'(nest_lvl), 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1;
    rd(12); chk("t6_status", o_rdata, 0);
    cyc(0, 0, 0, 0, 0, 1); chk("t6_eret", o_addr, 0);
    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      int r;
      r = $urandom_range(0, 15);
      if (r < 2) cyc(1, 12, ($urandom_range(0, 63) & 32'h3E) | 32'($urandom_range(0, 3) != 0), 0, 0, 0);
      else if (r == 2) cyc(1, 11, m_reg[9] + $urandom_range(2, 12), 0, 0, 0);
      else if (r == 3) begin
        int a;
        a = $urandom_range(0, 7);
        a = (a == 0) ? 9 : (a == 1) ? 13 : (a == 2) ? 14 : $urandom_range(0, 31);
        cyc(1, a, $urandom, 0, 0, 0);
      end else if (r < 6) cyc(0, $urandom_range(0, 31), 0, $urandom, 0, 1);
      else cyc(0, $urandom_range(0, 31), 0, $urandom,
               ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
